// File: rtl/control_fsm.sv
// Multi-cycle control FSM for the RV32I core. Sequences the shared
// instruction/data memory, PC, IR, ALU operand muxes and register-file
// writeback, traps on illegal opcodes or stalled memory, and counts
// retired instructions.
module control_fsm #(
  parameter int INSTRET_WIDTH = 32,
  parameter int TIMEOUT       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               opcode,
  input  logic                     alu__zero,
  input  logic                     mem_ready,
  output logic                     cfsm__pc_update,
  output logic                     cfsm__ir_write,
  output logic                     cfsm__mem_read,
  output logic                     cfsm__mem_write,
  output logic                     cfsm__adr_src,
  output logic [1:0]               cfsm__alu_src_a,
  output logic [1:0]               cfsm__alu_src_b,
  output logic [1:0]               cfsm__alu_op,
  output logic [1:0]               cfsm__result_src,
  output logic                     cfsm__reg_write,
  output logic                     cfsm__trap,
  output logic [1:0]               trap_cause,
  output logic [3:0]               cfsm__state,
  output logic [INSTRET_WIDTH-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_LUI       = 4'd11,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Wait counter only ever needs to reach TIMEOUT-1.
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cause_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_st;
  logic             timeout_hit;

  // Raw per-state enables, gated by reset before leaving the block.
  logic pc_update_c;
  logic ir_write_c;
  logic mem_read_c;
  logic mem_write_c;
  logic reg_write_c;

  assign wait_st = (state == S_FETCH) || (state == S_MEM_READ) ||
                   (state == S_MEM_WRITE);
  assign timeout_hit = (TIMEOUT > 0) && wait_st && !mem_ready &&
                       (wait_cnt == CNT_LAST);

  // Next-state and trap-cause selection.
  always_comb begin
    state_nxt = state;
    cause_nxt = trap_cause;
    case (state)
      S_FETCH:     if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEM_ADR;
          OP_R:         state_nxt = S_EXEC_R;
          OP_I:         state_nxt = S_EXEC_I;
          OP_BR:        state_nxt = S_BRANCH;
          OP_JAL:       state_nxt = S_JAL;
          OP_LUI:       state_nxt = S_LUI;
          default: begin
            state_nxt = S_TRAP;
            cause_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADR:   state_nxt = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_nxt = S_FETCH;
      S_MEM_WB:    state_nxt = S_FETCH;
      S_EXEC_R:    state_nxt = S_ALU_WB;
      S_EXEC_I:    state_nxt = S_ALU_WB;
      S_ALU_WB:    state_nxt = S_FETCH;
      S_BRANCH:    state_nxt = S_FETCH;
      S_JAL:       state_nxt = S_ALU_WB;
      S_LUI:       state_nxt = S_FETCH;
      S_TRAP:      state_nxt = S_TRAP;
      default:     state_nxt = S_FETCH;
    endcase
    // A stalled memory wait overrides the normal "stay" decision.
    if (timeout_hit) begin
      state_nxt = S_TRAP;
      cause_nxt = CAUSE_TIMEOUT;
    end
  end

  // State, wait counter, trap cause and retired-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      trap_cause <= 2'b00;
      instret    <= '0;
    end else begin
      state      <= state_nxt;
      trap_cause <= cause_nxt;
      if (wait_st && !mem_ready && (state_nxt == state))
        wait_cnt <= wait_cnt + CNT_W'(1);
      else
        wait_cnt <= '0;
      // Retirement is the return to FETCH; a trap never retires.
      if ((state_nxt == S_FETCH) && (state != S_FETCH))
        instret <= instret + INSTRET_WIDTH'(1);
    end
  end

  // Per-state control decode; unlisted selects default to zero.
  always_comb begin
    pc_update_c      = 1'b0;
    ir_write_c       = 1'b0;
    mem_read_c       = 1'b0;
    mem_write_c      = 1'b0;
    reg_write_c      = 1'b0;
    cfsm__adr_src    = 1'b0;
    cfsm__alu_src_a  = 2'b00;
    cfsm__alu_src_b  = 2'b00;
    cfsm__alu_op     = 2'b00;
    cfsm__result_src = 2'b00;
    case (state)
      S_FETCH: begin
        mem_read_c       = 1'b1;
        cfsm__alu_src_b  = 2'b10;
        cfsm__result_src = 2'b10;
        ir_write_c       = mem_ready;
        pc_update_c      = mem_ready;
      end
      S_DECODE: begin
        cfsm__alu_src_a = 2'b01;
        cfsm__alu_src_b = 2'b01;
      end
      S_MEM_ADR: begin
        cfsm__alu_src_a = 2'b10;
        cfsm__alu_src_b = 2'b01;
      end
      S_MEM_READ: begin
        mem_read_c    = 1'b1;
        cfsm__adr_src = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_c   = 1'b1;
        cfsm__adr_src = 1'b1;
      end
      S_MEM_WB: begin
        cfsm__result_src = 2'b01;
        reg_write_c      = 1'b1;
      end
      S_EXEC_R: begin
        cfsm__alu_src_a = 2'b10;
        cfsm__alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        cfsm__alu_src_a = 2'b10;
        cfsm__alu_src_b = 2'b01;
        cfsm__alu_op    = 2'b10;
      end
      S_ALU_WB: reg_write_c = 1'b1;
      S_BRANCH: begin
        cfsm__alu_src_a = 2'b10;
        cfsm__alu_op    = 2'b01;
        pc_update_c     = alu__zero;
      end
      S_JAL: begin
        cfsm__alu_src_a = 2'b01;
        cfsm__alu_src_b = 2'b10;
        pc_update_c     = 1'b1;
      end
      S_LUI: begin
        cfsm__result_src = 2'b11;
        reg_write_c      = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables drop the moment reset goes low, even mid-cycle.
  assign cfsm__pc_update = pc_update_c & reset;
  assign cfsm__ir_write  = ir_write_c  & reset;
  assign cfsm__mem_read  = mem_read_c  & reset;
  assign cfsm__mem_write = mem_write_c & reset;
  assign cfsm__reg_write = reg_write_c & reset;

  assign cfsm__trap  = (state == S_TRAP);
  assign cfsm__state = state;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: a per-cycle vector table for the normal
// instruction flows, then hand sequences for traps, timeout and reset.
module tb_control_fsm;

  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic          alu__zero;
  logic          mem_ready;
  logic          pc_update, ir_write, mem_read, mem_write, adr_src;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, result_src;
  logic          reg_write, trap;
  logic [1:0]    trap_cause;
  logic [3:0]    state;
  logic [IW-1:0] instret;

  int n_cmp  = 0;
  int n_fail = 0;

  control_fsm #(.INSTRET_WIDTH(IW), .TIMEOUT(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .opcode           (opcode),
    .alu__zero        (alu__zero),
    .mem_ready        (mem_ready),
    .cfsm__pc_update  (pc_update),
    .cfsm__ir_write   (ir_write),
    .cfsm__mem_read   (mem_read),
    .cfsm__mem_write  (mem_write),
    .cfsm__adr_src    (adr_src),
    .cfsm__alu_src_a  (alu_src_a),
    .cfsm__alu_src_b  (alu_src_b),
    .cfsm__alu_op     (alu_op),
    .cfsm__result_src (result_src),
    .cfsm__reg_write  (reg_write),
    .cfsm__trap       (trap),
    .trap_cause       (trap_cause),
    .cfsm__state      (state),
    .instret          (instret)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;
  localparam logic [6:0] OP_LUI = 7'h37;

  typedef struct {
    logic [6:0]    op;
    logic          rdy;
    logic          z;
    logic [3:0]    st;
    logic          pcu, irw, mrd, mwr, adr;
    logic [1:0]    sa, sb, aop, res;
    logic          rw;
    logic [IW-1:0] ir;
  } vec_t;

  vec_t tbl [35];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] enables();
    return {pc_update, ir_write, mem_read, mem_write, reg_write};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            op     rdy z  st  pcu irw mrd mwr adr sa sb aop res rw ir
    tbl[0]  = '{OP_R,   1, 0, 0,  1, 1, 1, 0, 0, 0, 2, 0, 2, 0, 0};
    tbl[1]  = '{OP_R,   1, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{OP_R,   1, 0, 6,  0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0};
    tbl[3]  = '{OP_R,   1, 0, 8,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[4]  = '{OP_I,   1, 0, 0,  1, 1, 1, 0, 0, 0, 2, 0, 2, 0, 1};
    tbl[5]  = '{OP_I,   1, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
    tbl[6]  = '{OP_I,   1, 0, 7,  0, 0, 0, 0, 0, 2, 1, 2, 0, 0, 1};
    tbl[7]  = '{OP_I,   1, 0, 8,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[8]  = '{OP_LW,  1, 0, 0,  1, 1, 1, 0, 0, 0, 2, 0, 2, 0, 2};
    tbl[9]  = '{OP_LW,  1, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2};
    tbl[10] = '{OP_LW,  1, 0, 2,  0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 2};
    tbl[11] = '{OP_LW,  0, 0, 3,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2};
    tbl[12] = '{OP_LW,  0, 0, 3,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2};
    tbl[13] = '{OP_LW,  0, 0, 3,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2};
    tbl[14] = '{OP_LW,  1, 0, 3,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2};
    tbl[15] = '{OP_LW,  1, 0, 4,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2};
    tbl[16] = '{OP_SW,  1, 0, 0,  1, 1, 1, 0, 0, 0, 2, 0, 2, 0, 3};
    tbl[17] = '{OP_SW,  1, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3};
    tbl[18] = '{OP_SW,  1, 0, 2,  0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 3};
    tbl[19] = '{OP_SW,  1, 0, 5,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3};
    tbl[20] = '{OP_BR,  1, 1, 0,  1, 1, 1, 0, 0, 0, 2, 0, 2, 0, 4};
    tbl[21] = '{OP_BR,  1, 1, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4};
    tbl[22] = '{OP_BR,  1, 1, 9,  1, 0, 0, 0, 0, 2, 0, 1, 0, 0, 4};
    tbl[23] = '{OP_BR,  1, 0, 0,  1, 1, 1, 0, 0, 0, 2, 0, 2, 0, 5};
    tbl[24] = '{OP_BR,  1, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 5};
    tbl[25] = '{OP_BR,  1, 0, 9,  0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 5};
    tbl[26] = '{OP_JAL, 1, 0, 0,  1, 1, 1, 0, 0, 0, 2, 0, 2, 0, 6};
    tbl[27] = '{OP_JAL, 1, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 6};
    tbl[28] = '{OP_JAL, 1, 0, 10, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 6};
    tbl[29] = '{OP_JAL, 1, 0, 8,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6};
    tbl[30] = '{OP_LUI, 1, 0, 0,  1, 1, 1, 0, 0, 0, 2, 0, 2, 0, 7};
    tbl[31] = '{OP_LUI, 1, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 7};
    tbl[32] = '{OP_LUI, 1, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 7};
    tbl[33] = '{OP_R,   0, 0, 0,  0, 0, 1, 0, 0, 0, 2, 0, 2, 0, 0};
    tbl[34] = '{OP_R,   1, 0, 0,  1, 1, 1, 0, 0, 0, 2, 0, 2, 0, 0};

    // Reset held low for two cycles with memory ready.
    reset = 1'b1; opcode = OP_R; alu__zero = 1'b0; mem_ready = 1'b1;
    #3 reset = 1'b0;
    repeat (2) tick();
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_enables", 32'(enables()), 32'd0);
    check("reset_instret", 32'(instret), 32'd0);
    check("reset_trap", 32'({trap, trap_cause}), 32'd0);
    tick();
    reset = 1'b1;

    // Normal instruction flows, one table row per cycle.
    for (int i = 0; i < 35; i++) begin
      opcode = tbl[i].op; mem_ready = tbl[i].rdy; alu__zero = tbl[i].z;
      #1;
      check($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].st));
      check($sformatf("row%0d_ctl", i),
            32'({pc_update, ir_write, mem_read, mem_write, adr_src, alu_src_a,
                 alu_src_b, alu_op, result_src, reg_write, trap, trap_cause}),
            32'({tbl[i].pcu, tbl[i].irw, tbl[i].mrd, tbl[i].mwr, tbl[i].adr,
                 tbl[i].sa, tbl[i].sb, tbl[i].aop, tbl[i].res, tbl[i].rw,
                 3'b000}));
      check($sformatf("row%0d_instret", i), 32'(instret), 32'(tbl[i].ir));
      tick();
    end

    // Illegal opcode in DECODE: sticky trap with cause 01.
    opcode = 7'b0000000; mem_ready = 1'b1;
    #1 check("illegal_decode_state", 32'(state), 32'd1);
    tick();
    check("illegal_trap_state", 32'(state), 32'd15);
    check("illegal_trap_flag", 32'({trap, trap_cause}), 32'b101);
    check("illegal_trap_enables", 32'(enables()), 32'd0);
    for (int i = 0; i < 20; i++) begin
      opcode = 7'($urandom); mem_ready = 1'(i % 2);
      tick();
      check($sformatf("trap_hold%0d", i),
            32'({state, trap, trap_cause, instret}), 32'({4'd15, 1'b1, 2'b01, 3'd0}));
    end

    // Reset releases the trap; first FETCH after release loads IR and PC.
    opcode = OP_R; mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("trap_reset_state", 32'(state), 32'd0);
    check("trap_reset_flags", 32'({trap, trap_cause, enables()}), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1 check("release_fetch_ctl", 32'({state, ir_write, pc_update}), 32'({4'd0, 2'b11}));
    tick();
    check("release_decode", 32'(state), 32'd1);

    // Sixteen not-ready cycles in FETCH trap with cause 10.
    do_reset();
    mem_ready = 1'b0;
    repeat (15) tick();
    check("timeout_15_state", 32'(state), 32'd0);
    tick();
    check("timeout_16_trap", 32'({state, trap, trap_cause}), 32'({4'd15, 1'b1, 2'b10}));
    check("timeout_instret", 32'(instret), 32'd0);

    // Ready on the final allowed cycle advances normally.
    do_reset();
    mem_ready = 1'b0;
    repeat (15) tick();
    mem_ready = 1'b1;
    #1 check("late_ready_irw", 32'({state, ir_write}), 32'({4'd0, 1'b1}));
    tick();
    check("late_ready_decode", 32'({state, trap, trap_cause}), 32'({4'd1, 3'b000}));

    // Reset in the middle of a lw memory wait.
    opcode = OP_LW;
    tick();
    tick();
    mem_ready = 1'b0;
    #1 check("lw_mem_read", 32'({state, mem_read, adr_src}), 32'({4'd3, 2'b11}));
    #3 reset = 1'b0;
    #1;
    check("lw_abort_state", 32'(state), 32'd0);
    check("lw_abort_enables", 32'(enables()), 32'd0);
    tick();
    reset = 1'b1;
    mem_ready = 1'b1;
    #1 check("lw_abort_fetch", 32'({state, mem_read, adr_src}), 32'({4'd0, 2'b10}));
    tick();
    check("lw_abort_decode", 32'({state, instret}), 32'({4'd1, 3'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences the shared instruction/data memory, the PC register (drives cfsm__pc_update into fetch), the IR, the ALU muxes and register-file writeback.
- Handles a ready-based memory handshake, traps on illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- INSTRET_WIDTH, 32: width of the retired-instruction counter.
- TIMEOUT, 16: consecutive not-ready cycles in a memory wait state before trapping; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  7  instr[6:0] from the IR
- alu__zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current access this cycle
- cfsm__pc_update  out  1  load PC from the result bus
- cfsm__ir_write  out  1  latch fetched word into IR and old-PC
- cfsm__mem_read  out  1  memory read request
- cfsm__mem_write  out  1  memory write request
- cfsm__adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- cfsm__alu_src_a  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1
- cfsm__alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = const 4
- cfsm__alu_op  out  2  00 = add, 01 = sub, 10 = funct decode
- cfsm__result_src  out  2  result bus select: 00 = ALUOut, 01 = data reg, 10 = ALU result, 11 = imm
- cfsm__reg_write  out  1  register-file write enable
- cfsm__trap  out  1  core halted
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout
- cfsm__state  out  4  current state encoding, for debug
- instret  out  INSTRET_WIDTH  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JAL=10, LUI=11, TRAP=15.
- Reset asserted (reset=0), asynchronously:
  - state=FETCH; instret=0; wait counter=0; trap=0; trap_cause=00.
  - All enables (pc_update, ir_write, mem_read, mem_write, reg_write) forced 0 while reset is low.
  - Selects take their FETCH values.
- Any select not listed for a state is 00/0.
- FETCH:
  - mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_update = mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE:
  - alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jump target into ALUOut).
  - Next state by opcode: 0000011/0100011 -> MEM_ADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; 0110111 -> LUI; any other -> TRAP with cause 01.
- MEM_ADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, adr_src=1. mem_ready=1 -> MEM_WB.
- MEM_WRITE: mem_write=1, adr_src=1. mem_ready=1 -> FETCH.
- MEM_WB: result_src=01, reg_write=1 -> FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALU_WB.
- EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALU_WB.
- ALU_WB: result_src=00, reg_write=1 -> FETCH.
- BRANCH:
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_update=alu__zero -> FETCH.
- JAL:
  - alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1 -> ALU_WB.
  - ALU_WB then writes old PC+4 into rd.
- LUI: result_src=11, reg_write=1 -> FETCH.
- TRAP:
  - All enables 0, trap=1, trap_cause held.
  - Sticky until reset; opcode and mem_ready are ignored.
- Latencies with mem_ready always 1, counted in cycles from FETCH:
  - R/I-type, jal: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, lui: 3 cycles.
- Wait counter:
  - Counts consecutive cycles in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Cleared on any state change or whenever mem_ready=1.
- Timeout (TIMEOUT>0): when mem_ready=0 and counter==TIMEOUT-1, the next state is TRAP with cause 10. TIMEOUT consecutive not-ready cycles therefore trap; if mem_ready=1 on that final cycle, the state advances normally.
- instret:
  - Increments by 1 on every clock edge that moves the state into FETCH from a non-FETCH state.
  - Wraps modulo 2^INSTRET_WIDTH.
  - Never increments on entry to TRAP.
- Reset mid-instruction: the operation is abandoned, with no write enable asserted after reset falls. The next fetch starts from FETCH on the first edge after reset rises.

Test Plan:
- Reset low for 2 cycles with mem_ready=1 -> state=0, all enables 0, instret=0, trap=0. After release, first edge: state=1, with ir_write=pc_update=1 in the preceding FETCH cycle.
- opcode=0110011, mem_ready=1 -> states 0,1,6,8,0. reg_write=1 only in state 8. instret goes 0->1 on the 4th edge.
- opcode=0000011, mem_ready low for 3 cycles in MEM_READ -> FETCH, DECODE, MEM_ADR, MEM_READ x4, MEM_WB, FETCH. mem_read=1 and adr_src=1 throughout MEM_READ. reg_write with result_src=01 for one cycle.
- opcode=1100011: alu__zero=1 -> pc_update=1 in BRANCH. alu__zero=0 -> pc_update=0. Both take 3 cycles and increment instret.
- opcode=0000000 -> TRAP after DECODE with trap_cause=01. State stays 15 for 20 cycles; instret unchanged.
- TIMEOUT=16, mem_ready=0 in FETCH for 16 cycles -> TRAP with cause 10. Repeat with mem_ready=1 on the 16th cycle -> DECODE, no trap. Then reset mid-lw in MEM_READ -> enables drop immediately and state=0.
